c_writeback_buffer: RTL and testbench
=====================================

Name: c_writeback_buffer

Overview:
- Sits directly downstream of top_control_fsm and consumes its C-result write port (write_en_C, write_addr_C, C_in).
- Decouples the accelerator from a result memory that can stall, using a small FIFO and a valid/ready drain interface.
- Range-checks addresses, tracks which C entries of the N×N tile have been committed, and flags overflow and duplicate writes.
- On flush request, drains all pending writes and reports completion to the host.

Parameters:
- N, 3, matrix dimension; the tile holds N*N C entries.
- W, 8, operand width; C data width is 2*W.
- DEPTH, 4, FIFO entries; power of two, at least 2.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high
- write_en_C  in  1  result write strobe from top_control_fsm
- write_addr_C  in  32  C linear index (row*N+col)
- C_in  in  2*W  signed result value
- flush_req  in  1  one-cycle pulse, driven from done_all
- mem_wr_en  out  1  valid: head entry presented to memory
- mem_wr_addr  out  32  head entry address
- mem_wr_data  out  2*W  head entry data
- mem_ready  in  1  memory accepts when mem_wr_en && mem_ready
- buf_full  out  1  FIFO holds DEPTH entries
- buf_empty  out  1  FIFO holds 0 entries
- tile_complete  out  1  one-cycle pulse once all N*N addresses are committed
- flush_done  out  1  one-cycle pulse when a flush finishes
- overflow_err  out  1  sticky; a write was dropped because the FIFO was full
- range_err  out  1  sticky; a write had address ≥ N*N
- dup_err  out  1  sticky; an already-committed address was committed again
- committed_count  out  32  total accepted memory writes since reset

Behaviour:
- Reset (synchronous; applies mid-operation, discarding FIFO contents):
  - All outputs are 0 except buf_empty=1.
  - Pointers, bitmap and counters clear; FSM goes to IDLE.

Push:
- Accept when write_en_C && write_addr_C < N*N && (!buf_full || pop_this_cycle).
- Simultaneous push and pop while full is accepted; occupancy stays unchanged.
- If write_en_C is high and the address is ≥ N*N: no push, set range_err.
- If the address is in range but full with no pop: drop the write, set overflow_err.
- Push while empty: mem_wr_en rises the next cycle (1-cycle latency, registered FIFO storage).

Pop:
- Occurs when mem_wr_en && mem_ready.
- mem_wr_addr and mem_wr_data stay stable while mem_wr_en=1 and mem_ready=0.
- mem_wr_en = !buf_empty.

Commit bitmap (N*N bits):
- On pop: if bitmap[addr] is already 1, set dup_err. Then set bitmap[addr] and increment committed_count (wraps at 2^32).
- When the bitmap becomes all-ones, pulse tile_complete in the following cycle and clear the bitmap in that same cycle.
- A pop in the clear cycle is applied after the clear.

FSM states:
- IDLE:
  - Go to RUN on the first accepted push.
  - On flush_req, go to FLUSH.
- RUN:
  - On flush_req, go to FLUSH.
- FLUSH:
  - Pushes are still accepted.
  - When buf_empty && !write_en_C, go to DONE.
- DONE:
  - flush_done=1 for exactly one cycle, then go to IDLE.
- flush_req in FLUSH or DONE is ignored.
- flush_req in IDLE with an empty FIFO: flush_done two cycles later.

Arithmetic:
- Data passes through unmodified; no saturation.
- Occupancy counter is clog2(DEPTH)+1 bits.

Decomposition:
- Shared package wb_pkg holds:
  - state enum {IDLE, RUN, FLUSH, DONE}
  - C_ADDR_W=32
  - helper function in_range(addr, N)
- One sub-module, wb_fifo, parameterised by DEPTH and data width 32+2*W:
  - push, pop, full, empty, head
  - fall-through-free registered head
- The FSM, range check, bitmap and error flags live in c_writeback_buffer.

Test Plan:
1. Matrices A=[7 8 9;0 6 5;2 0 4], B=[3 5 1;4 2 7;6 0 8]; results streamed at addresses 0..8 with mem_ready=1:
   - memory receives 107, 51, 135, 54, 12, 82, 30, 10, 34 in order.
   - tile_complete pulses once; committed_count=9; no error flag set.
2. mem_ready=0 for 10 cycles during 6 back-to-back writes (DEPTH=4):
   - first 4 are buffered and buf_full=1; writes 5 and 6 are dropped and overflow_err=1.
   - after release, exactly 4 memory writes occur with stable addr/data while stalled.
3. Full FIFO with mem_ready=1 and write_en_C in the same cycle:
   - push accepted, occupancy stays at 4, no overflow_err.
4. Write to address 9 (N=3): range_err=1, nothing enqueued. Address 4 written twice: dup_err=1 on the second commit.
5. flush_req while 3 entries are pending and mem_ready toggles 1/0:
   - all 3 drain, then flush_done pulses exactly one cycle.
   - flush_req on an idle, empty buffer: flush_done two cycles later.
6. Reset asserted with 2 entries queued:
   - next cycle mem_wr_en=0, buf_empty=1, all sticky errors=0, committed_count=0.

Source files
------------

// File: rtl/wb_pkg.sv
// Shared types and helpers for the C-result writeback buffer.
package wb_pkg;

  // Address width of the C write port and of the memory drain port.
  localparam int unsigned C_ADDR_W = 32;

  // Flush/drain controller states.
  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StFlush,
    StDone
  } wb_state_e;

  // True when a linear C index falls inside an n x n tile.
  function automatic logic in_range(input logic [C_ADDR_W-1:0] addr, input int unsigned n);
    return addr < C_ADDR_W'(n * n);
  endfunction

endpackage

// File: rtl/wb_fifo.sv
// Small synchronous FIFO with a registered head: an entry pushed into an empty
// FIFO becomes visible on head_o one cycle later.
module wb_fifo #(
  parameter int unsigned Depth = 4,
  parameter int unsigned Width = 48
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [Width-1:0] din_i,
  output logic             full_o,
  output logic             empty_o,
  output logic [Width-1:0] head_o
);

  localparam int unsigned PtrW = $clog2(Depth);
  localparam int unsigned CntW = PtrW + 1;

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]  count_q, count_d;
  logic             do_push, do_pop;

  assign full_o  = (count_q == CntW'(Depth));
  assign empty_o = (count_q == '0);
  assign head_o  = mem_q[rd_ptr_q];

  // A push into a full FIFO is only legal when the head leaves in the same cycle.
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  // Next-state for pointers and occupancy; pointers wrap naturally (Depth is 2^k).
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + PtrW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + PtrW'(1);
    count_d = count_q + CntW'(do_push) - CntW'(do_pop);
  end

  // Pointer and occupancy registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage; contents are don't-care while not counted as occupied.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= din_i;
  end

endmodule

// File: rtl/c_writeback_buffer.sv
// Buffers C-result writes from the control FSM, drains them to a stallable
// memory, tracks committed tile entries and handles host flush requests.
module c_writeback_buffer
  import wb_pkg::*;
#(
  parameter int unsigned N     = 3,
  parameter int unsigned W     = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       write_en_C,
  input  logic [C_ADDR_W-1:0]        write_addr_C,
  input  logic signed [2*W-1:0]      C_in,
  input  logic                       flush_req,
  output logic                       mem_wr_en,
  output logic [C_ADDR_W-1:0]        mem_wr_addr,
  output logic signed [2*W-1:0]      mem_wr_data,
  input  logic                       mem_ready,
  output logic                       buf_full,
  output logic                       buf_empty,
  output logic                       tile_complete,
  output logic                       flush_done,
  output logic                       overflow_err,
  output logic                       range_err,
  output logic                       dup_err,
  output logic [31:0]                committed_count
);

  localparam int unsigned Cells = N * N;
  localparam int unsigned IdxW  = (Cells > 1) ? $clog2(Cells) : 1;
  localparam int unsigned EntW  = C_ADDR_W + 2 * W;

  wb_state_e         state_q, state_d;
  logic [Cells-1:0]  bitmap_q, bitmap_d;
  logic              overflow_q, overflow_d;
  logic              range_q, range_d;
  logic              dup_q, dup_d;
  logic [31:0]       count_q, count_d;

  logic              addr_ok;
  logic              push, pop;
  logic              dup_hit;
  logic [IdxW-1:0]   pop_idx;
  logic [EntW-1:0]   head;

  assign addr_ok   = in_range(write_addr_C, N);
  assign mem_wr_en = !buf_empty;
  assign pop       = mem_wr_en && mem_ready;
  // Full FIFO still accepts when the head drains this cycle.
  assign push      = write_en_C && addr_ok && (!buf_full || pop);

  assign mem_wr_addr = head[EntW-1:2*W];
  assign mem_wr_data = head[2*W-1:0];
  assign pop_idx     = mem_wr_addr[IdxW-1:0];

  wb_fifo #(
    .Depth (DEPTH),
    .Width (EntW)
  ) u_fifo (
    .clk_i   (clk),
    .reset_i (reset),
    .push_i  (push),
    .pop_i   (pop),
    .din_i   ({write_addr_C, C_in}),
    .full_o  (buf_full),
    .empty_o (buf_empty),
    .head_o  (head)
  );

  // High for the single cycle in which the registered bitmap is all ones.
  assign tile_complete = &bitmap_q;

  // Bitmap update: the tile-complete clear happens first, then this cycle's pop.
  always_comb begin
    bitmap_d = bitmap_q;
    dup_hit  = 1'b0;
    if (tile_complete) bitmap_d = '0;
    if (pop) begin
      dup_hit           = bitmap_d[pop_idx];
      bitmap_d[pop_idx] = 1'b1;
    end
  end

  // Sticky error flags and the commit counter.
  always_comb begin
    overflow_d = overflow_q;
    range_d    = range_q;
    dup_d      = dup_q;
    count_d    = count_q;
    if (write_en_C && !addr_ok)                    range_d    = 1'b1;
    if (write_en_C && addr_ok && buf_full && !pop) overflow_d = 1'b1;
    if (dup_hit)                                   dup_d      = 1'b1;
    if (pop)                                       count_d    = count_q + 32'd1;
  end

  // Flush controller next-state and outputs.
  always_comb begin
    state_d    = state_q;
    flush_done = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (flush_req)  state_d = StFlush;
        else if (push)  state_d = StRun;
      end
      StRun: begin
        if (flush_req) state_d = StFlush;
      end
      StFlush: begin
        if (buf_empty && !write_en_C) state_d = StDone;
      end
      StDone: begin
        flush_done = 1'b1;
        state_d    = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StIdle;
      bitmap_q   <= '0;
      overflow_q <= 1'b0;
      range_q    <= 1'b0;
      dup_q      <= 1'b0;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      bitmap_q   <= bitmap_d;
      overflow_q <= overflow_d;
      range_q    <= range_d;
      dup_q      <= dup_d;
      count_q    <= count_d;
    end
  end

  assign overflow_err    = overflow_q;
  assign range_err       = range_q;
  assign dup_err         = dup_q;
  assign committed_count = count_q;

endmodule

// File: tb/tb_c_writeback_buffer.sv
// Self-checking bench for c_writeback_buffer: directed scenarios plus random
// traffic, all compared against a queue-based reference model.
module tb_c_writeback_buffer;

  localparam int unsigned N     = 3;
  localparam int unsigned W     = 8;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned CELLS = N * N;

  logic               clk = 1'b0;
  logic               reset;
  logic               write_en_C;
  logic [31:0]        write_addr_C;
  logic signed [15:0] C_in;
  logic               flush_req;
  logic               mem_wr_en;
  logic [31:0]        mem_wr_addr;
  logic signed [15:0] mem_wr_data;
  logic               mem_ready;
  logic               buf_full, buf_empty, tile_complete, flush_done;
  logic               overflow_err, range_err, dup_err;
  logic [31:0]        committed_count;

  always #5 clk = ~clk;

  c_writeback_buffer #(.N(N), .W(W), .DEPTH(DEPTH)) dut (
    .clk             (clk),
    .reset           (reset),
    .write_en_C      (write_en_C),
    .write_addr_C    (write_addr_C),
    .C_in            (C_in),
    .flush_req       (flush_req),
    .mem_wr_en       (mem_wr_en),
    .mem_wr_addr     (mem_wr_addr),
    .mem_wr_data     (mem_wr_data),
    .mem_ready       (mem_ready),
    .buf_full        (buf_full),
    .buf_empty       (buf_empty),
    .tile_complete   (tile_complete),
    .flush_done      (flush_done),
    .overflow_err    (overflow_err),
    .range_err       (range_err),
    .dup_err         (dup_err),
    .committed_count (committed_count)
  );

  typedef struct {
    logic [31:0] a;
    logic [15:0] d;
  } ent_t;

  typedef struct {
    int unsigned addr;
    logic [15:0] din;
    logic [15:0] exp;
  } vec_t;

  // Reference model: pending writes as a queue, committed set, flags, mode.
  ent_t        mq[$];
  ent_t        wlog[$];
  bit          m_seen[CELLS];
  bit          m_tc, m_ovf, m_rng, m_dup;
  logic [31:0] m_cnt;
  int          m_mode;  // 0 idle, 1 run, 2 flush, 3 done

  int checks = 0;
  int errors = 0;
  int tc_seen, fd_seen;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    foreach (m_seen[i]) m_seen[i] = 1'b0;
    m_tc = 0; m_ovf = 0; m_rng = 0; m_dup = 0;
    m_cnt = '0;
    m_mode = 0;
  endtask

  task automatic model_step(input bit we, input logic [31:0] a, input logic [15:0] d,
                            input bit rdy, input bit fl);
    int   pre;
    bit   popping, acc, all;
    ent_t e;
    pre     = mq.size();
    popping = (pre > 0) && rdy;
    acc     = 0;
    if (m_tc) begin
      foreach (m_seen[i]) m_seen[i] = 1'b0;
      m_tc = 0;
    end
    if (popping) begin
      e = mq.pop_front();
      if (m_seen[e.a]) m_dup = 1;
      m_seen[e.a] = 1;
      m_cnt = m_cnt + 1;
    end
    all = 1;
    foreach (m_seen[i]) if (!m_seen[i]) all = 0;
    m_tc = all;
    if (we) begin
      if (a >= CELLS) m_rng = 1;
      else if (pre == DEPTH && !popping) m_ovf = 1;
      else begin
        e.a = a; e.d = d;
        mq.push_back(e);
        acc = 1;
      end
    end
    case (m_mode)
      0: if (fl) m_mode = 2; else if (acc) m_mode = 1;
      1: if (fl) m_mode = 2;
      2: if (pre == 0 && !we) m_mode = 3;
      default: m_mode = 0;
    endcase
  endtask

  task automatic compare_all();
    chk1("mem_wr_en", mem_wr_en, mq.size() > 0);
    if (mq.size() > 0) begin
      chk("mem_wr_addr", mem_wr_addr, mq[0].a);
      chk("mem_wr_data", {16'd0, mem_wr_data}, {16'd0, mq[0].d});
    end
    chk1("buf_full", buf_full, mq.size() == DEPTH);
    chk1("buf_empty", buf_empty, mq.size() == 0);
    chk1("tile_complete", tile_complete, m_tc);
    chk1("flush_done", flush_done, m_mode == 3);
    chk1("overflow_err", overflow_err, m_ovf);
    chk1("range_err", range_err, m_rng);
    chk1("dup_err", dup_err, m_dup);
    chk("committed_count", committed_count, m_cnt);
  endtask

  // One clock cycle: drive inputs, log accepted memory writes, step model, compare.
  task automatic cyc(input bit we, input logic [31:0] a, input logic [15:0] d,
                     input bit rdy, input bit fl);
    ent_t e;
    write_en_C   = we;
    write_addr_C = a;
    C_in         = d;
    mem_ready    = rdy;
    flush_req    = fl;
    if (mem_wr_en && mem_ready) begin
      e.a = mem_wr_addr; e.d = mem_wr_data;
      wlog.push_back(e);
    end
    @(posedge clk);
    #1;
    model_step(we, a, d, rdy, fl);
    compare_all();
    if (tile_complete) tc_seen++;
    if (flush_done) fd_seen++;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    write_en_C = 0; write_addr_C = '0; C_in = '0; mem_ready = 0; flush_req = 0;
    @(posedge clk);
    #1;
    reset = 1'b0;
    model_reset();
    compare_all();
    wlog.delete();
    tc_seen = 0;
    fd_seen = 0;
  endtask

  int   amat[3][3] = '{'{7, 8, 9}, '{0, 6, 5}, '{2, 0, 4}};
  int   bmat[3][3] = '{'{3, 5, 1}, '{4, 2, 7}, '{6, 0, 8}};
  int   exp_c[9]   = '{107, 51, 135, 54, 12, 82, 30, 10, 34};
  vec_t tv[9];

  initial begin
    int acc;
    reset = 1'b1;
    write_en_C = 0; write_addr_C = '0; C_in = '0; mem_ready = 0; flush_req = 0;
    @(posedge clk);
    #1;
    do_reset();

    // Test 1: matrix product streamed with memory always ready.
    for (int i = 0; i < 9; i++) begin
      acc = 0;
      for (int k = 0; k < 3; k++) acc += amat[i / 3][k] * bmat[k][i % 3];
      tv[i].addr = i;
      tv[i].din  = 16'(acc);
      tv[i].exp  = 16'(exp_c[i]);
    end
    for (int i = 0; i < 9; i++) cyc(1, tv[i].addr, tv[i].din, 1, 0);
    for (int i = 0; i < 4; i++) cyc(0, 0, 0, 1, 0);
    chk("t1_writes", wlog.size(), 9);
    for (int i = 0; i < 9; i++) begin
      if (i < wlog.size()) begin
        chk("t1_addr", wlog[i].a, tv[i].addr);
        chk("t1_data", {16'd0, wlog[i].d}, {16'd0, tv[i].exp});
      end
    end
    chk("t1_tile_pulses", tc_seen, 1);
    chk("t1_count", committed_count, 9);
    chk1("t1_errs", overflow_err | range_err | dup_err, 1'b0);

    // Test 2: stalled memory, six writes into a four-deep buffer.
    do_reset();
    for (int i = 0; i < 6; i++) cyc(1, i, 16'(100 + i), 0, 0);
    for (int i = 0; i < 4; i++) cyc(0, 0, 0, 0, 0);
    chk1("t2_full", buf_full, 1'b1);
    chk1("t2_overflow", overflow_err, 1'b1);
    chk("t2_head_addr", mem_wr_addr, 0);
    chk("t2_head_data", {16'd0, mem_wr_data}, 32'd100);
    for (int i = 0; i < 6; i++) cyc(0, 0, 0, 1, 0);
    chk("t2_writes", wlog.size(), 4);
    for (int i = 0; i < 4; i++)
      if (i < wlog.size()) chk("t2_addr", wlog[i].a, i);

    // Test 3: push and pop together while full.
    do_reset();
    for (int i = 0; i < 4; i++) cyc(1, i, 16'(200 + i), 0, 0);
    cyc(1, 5, 16'd205, 1, 0);
    chk1("t3_still_full", buf_full, 1'b1);
    chk1("t3_no_overflow", overflow_err, 1'b0);
    for (int i = 0; i < 6; i++) cyc(0, 0, 0, 1, 0);
    chk("t3_writes", wlog.size(), 5);

    // Test 4: out-of-range address and duplicate commit.
    do_reset();
    cyc(1, 9, 16'd1, 1, 0);
    chk1("t4_range", range_err, 1'b1);
    chk1("t4_empty", buf_empty, 1'b1);
    cyc(1, 4, 16'd44, 1, 0);
    cyc(0, 0, 0, 1, 0);
    chk1("t4_no_dup_yet", dup_err, 1'b0);
    cyc(1, 4, 16'd45, 1, 0);
    cyc(0, 0, 0, 1, 0);
    chk1("t4_dup", dup_err, 1'b1);

    // Test 5: flush with pending entries and toggling ready, then idle flush.
    do_reset();
    for (int i = 0; i < 3; i++) cyc(1, i, 16'(300 + i), 0, 0);
    for (int i = 0; i < 20; i++) cyc(0, 0, 0, (i % 2) == 0, i == 0);
    chk("t5_done_pulses", fd_seen, 1);
    chk("t5_writes", wlog.size(), 3);
    cyc(0, 0, 0, 1, 1);
    chk1("t5_idle_c1", flush_done, 1'b0);
    cyc(0, 0, 0, 1, 0);
    chk1("t5_idle_c2", flush_done, 1'b1);
    cyc(0, 0, 0, 1, 0);
    chk1("t5_idle_c3", flush_done, 1'b0);

    // Test 6: reset with two entries queued and errors set.
    do_reset();
    cyc(1, 0, 16'd7, 0, 0);
    cyc(1, 9, 16'd0, 1, 0);
    cyc(1, 1, 16'd8, 0, 0);
    cyc(1, 2, 16'd9, 0, 0);
    do_reset();
    chk1("t6_wr_en", mem_wr_en, 1'b0);
    chk1("t6_empty", buf_empty, 1'b1);
    chk1("t6_errs", overflow_err | range_err | dup_err, 1'b0);
    chk("t6_count", committed_count, 0);

    // Random traffic against the model.
    do_reset();
    for (int i = 0; i < 1500; i++) begin
      cyc($urandom_range(0, 2) != 0, $urandom_range(0, 11), 16'($urandom),
          $urandom_range(0, 3) != 0, $urandom_range(0, 39) == 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
